// File: rtl/param_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// param_sync_updown_counter
//
// Parametrised synchronous up/down counter with a runtime terminal value
// (limit), parallel load with clamping, a combinational cascade output (tc)
// and a registered one-cycle wrap pulse.
//
// Count range is 0..limit inclusive. Per-cycle priority: reset > load > enable.
//
// Optional build macro: COUNTER_SATURATE_EN
//   When defined, the counter saturates at the bounds instead of wrapping.
//   wrap then pulses the cycle after any enabled step that tried to go past
//   a bound. The down-count clamp (Count > limit) and the load clamp behave
//   the same in both builds.
// -----------------------------------------------------------------------------
module param_sync_updown_counter #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] Count,
    output logic [WIDTH-1:0] CountBar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO = WIDTH'(1'b0);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    // State
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    // Decoded conditions on the current count
    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] count_inc_s;
    logic [WIDTH-1:0] count_dec_s;
    logic             at_top_s;
    logic             at_zero_s;
    logic             above_limit_s;
    logic             eq_limit_s;

    // Comparators, clamped load value and the +/-1 neighbours of the count
    always_comb begin
        at_top_s       = (count_q >= limit);
        eq_limit_s     = (count_q == limit);
        at_zero_s      = (count_q == ZERO);
        above_limit_s  = (count_q > limit);
        count_inc_s    = count_q + ONE;
        count_dec_s    = count_q - ONE;
        if (load_value > limit) begin
            load_clamped_s = limit;
        end else begin
            load_clamped_s = load_value;
        end
    end

    // Next-state logic: load beats enable; reset is handled in the register
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped_s;
            wrap_d  = 1'b0;
        end else if (enable) begin
            if (up_down) begin
                if (at_top_s) begin
`ifdef COUNTER_SATURATE_EN
                    count_d = limit;
`else
                    count_d = ZERO;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_inc_s;
                    wrap_d  = 1'b0;
                end
            end else begin
                if (at_zero_s) begin
`ifdef COUNTER_SATURATE_EN
                    count_d = ZERO;
`else
                    count_d = limit;
`endif
                    wrap_d  = 1'b1;
                end else if (above_limit_s) begin
                    // limit was lowered below the current count: snap to it
                    count_d = limit;
                    wrap_d  = 1'b0;
                end else begin
                    count_d = count_dec_s;
                    wrap_d  = 1'b0;
                end
            end
        end else begin
            count_d = count_q;
            wrap_d  = 1'b0;
        end
    end

    // Count and wrap registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Outputs: CountBar follows Count; tc is live so cascaded stages see it
    // in the same cycle
    assign Count    = count_q;
    assign CountBar = ~count_q;
    assign wrap     = wrap_q;
    assign tc       = enable & ((up_down & eq_limit_s) | (~up_down & at_zero_s));

endmodule

// File: tb/tb_param_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for param_sync_updown_counter (WIDTH=4, RESET_VALUE=5).
// Each step drives inputs on the falling edge, checks tc against a reference
// model, pushes the expected post-edge state into a scoreboard queue, and
// pops/compares it shortly after the rising edge.
// Build with +define+COUNTER_SATURATE_EN to exercise the saturating variant.
// -----------------------------------------------------------------------------
module tb_param_sync_updown_counter;

    localparam int unsigned W  = 4;
    localparam logic [W-1:0] RV = 4'd5;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] limit;
    logic [W-1:0] Count;
    logic [W-1:0] CountBar;
    logic         tc;
    logic         wrap;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wrp;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks;
    int           n_fails;
    logic [W-1:0] mdl_cnt;
    logic         mdl_valid;

    param_sync_updown_counter #(
        .WIDTH      (W),
        .RESET_VALUE(RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .load      (load),
        .load_value(load_value),
        .limit     (limit),
        .Count     (Count),
        .CountBar  (CountBar),
        .tc        (tc),
        .wrap      (wrap)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of one clock edge
    function automatic exp_t model_next(input logic [W-1:0] cnt, input logic r, input logic en,
                                        input logic ud, input logic ld,
                                        input logic [W-1:0] lv, input logic [W-1:0] lim);
        exp_t e;
        int   c;
        int   l;
        c = int'(cnt);
        l = int'(lim);
        e.wrp = 1'b0;
        if (r) begin
            e.cnt = RV;
        end else if (ld) begin
            e.cnt = (int'(lv) > l) ? lim : lv;
        end else if (en && ud) begin
            if (c >= l) begin
`ifdef COUNTER_SATURATE_EN
                e.cnt = lim;
`else
                e.cnt = 4'd0;
`endif
                e.wrp = 1'b1;
            end else begin
                e.cnt = W'(c + 1);
            end
        end else if (en) begin
            if (c == 0) begin
`ifdef COUNTER_SATURATE_EN
                e.cnt = 4'd0;
`else
                e.cnt = lim;
`endif
                e.wrp = 1'b1;
            end else if (c > l) begin
                e.cnt = lim;
            end else begin
                e.cnt = W'(c - 1);
            end
        end else begin
            e.cnt = cnt;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic en, input logic ud, input logic ld,
                        input logic [W-1:0] lv, input logic [W-1:0] lim);
        exp_t e;
        logic exp_tc;
        @(negedge clk);
        reset      = r;
        enable     = en;
        up_down    = ud;
        load       = ld;
        load_value = lv;
        limit      = lim;
        #1;
        if (mdl_valid) begin
            exp_tc = en & ((ud & (mdl_cnt == lim)) | (~ud & (mdl_cnt == 4'd0)));
            check_eq("tc", {31'd0, tc}, {31'd0, exp_tc});
        end
        sb_q.push_back(model_next(mdl_cnt, r, en, ud, ld, lv, lim));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("count",    {28'd0, Count},    {28'd0, e.cnt});
        check_eq("countbar", {28'd0, CountBar}, {28'd0, ~e.cnt});
        check_eq("wrap",     {31'd0, wrap},     {31'd0, e.wrp});
        mdl_cnt   = e.cnt;
        mdl_valid = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        mdl_cnt    = 4'd0;
        mdl_valid  = 1'b0;
        reset      = 1'b1;
        enable     = 1'b0;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 4'd0;
        limit      = 4'd9;

        // Reset for two cycles, then hold three cycles
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
        check_eq("rst_hold_count",    {28'd0, Count},    32'd5);
        check_eq("rst_hold_countbar", {28'd0, CountBar}, 32'hA);
        check_eq("rst_hold_wrap",     {31'd0, wrap},     32'd0);

        // Up-count from 0 with limit 9, through the wrap
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
`ifndef COUNTER_SATURATE_EN
        check_eq("up_wrap_count", {28'd0, Count}, 32'd0);
        check_eq("up_wrap_pulse", {31'd0, wrap},  32'd1);
`endif

        // Down-count from 2 with limit 9: 1,0,9,8
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd9);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);

        // Load priority over enable, with clamping
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 4'd9);
        check_eq("load_clamp", {28'd0, Count}, 32'd9);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd9);
        check_eq("load_plain", {28'd0, Count}, 32'd3);

        // Reset beats load while Count==limit
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd9);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9);
        check_eq("rst_over_load", {28'd0, Count}, 32'd5);

        // limit=0: wrap/saturation pulse every enabled cycle, both directions
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        // Lowered limit while counting down snaps to limit without wrap
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3);

        // Full-range limit: natural binary wrap and immediate direction change
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 4'd15);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);

        // Saturation sequences (wrap sequences in the default build)
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd9);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/param_sync_updown_counter.md
Name: param_sync_updown_counter

Overview:
- Parametrised synchronous up/down counter; next generation of the team's fixed 3-bit synchronous up counter.
- Adds:
  - configurable width
  - runtime modulus (terminal value)
  - count direction
  - parallel load
  - cascadable terminal-count output
  - registered wrap pulse
- Used as a generic cycle/event counter in the RISC-V datapath and control (timers, loop/step counters, clock dividers).

Parameters:
- WIDTH, 8, counter width in bits (≥1).
- RESET_VALUE, 0, value of Count after reset; must be ≤ 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; when 0 the counter holds (load still honoured).
- up_down  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value to load.
- limit  input  WIDTH  terminal value; the count range is 0..limit inclusive.
- Count  output  WIDTH  registered count.
- CountBar  output  WIDTH  bitwise complement of Count, always ~Count.
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse when the count wraps.

Behaviour:
- One clock; reset is synchronous and active-high; ports named clk and reset.
- All state updates on rising clk.
- Priority per cycle: reset > load > enable.
- Reset:
  - Count = RESET_VALUE, CountBar = ~RESET_VALUE, wrap = 0.
  - Reset mid-count aborts the count on that edge; no wrap pulse.
- Load (load=1, reset=0):
  - Count <= load_value if load_value ≤ limit, else Count <= limit (clamped).
  - wrap <= 0; enable and up_down are ignored that cycle.
- Count up (enable=1, up_down=1, load=0):
  - if Count ≥ limit: Count <= 0, wrap <= 1.
  - else: Count <= Count+1, wrap <= 0.
- Count down (enable=1, up_down=0, load=0):
  - if Count == 0: Count <= limit, wrap <= 1.
  - if Count > limit (limit lowered at runtime): Count <= limit, wrap <= 0.
  - else: Count <= Count-1, wrap <= 0.
- Hold (enable=0, load=0): Count unchanged, wrap <= 0.
- Latency: Count reflects an enabled step one cycle after the edge sampling enable.
- wrap:
  - High for exactly the cycle after the wrapping edge.
  - Consecutive wraps (limit=0) give wrap high every enabled cycle.
- tc = enable & ((up_down & Count==limit) | (~up_down & Count==0)).
  - Combinational from registered Count and live inputs.
  - Drives the enable of the next cascaded stage.
- limit=0: Count stays 0 while enabled; tc=1 and wrap pulses every enabled cycle.
- limit=2^WIDTH-1: natural binary wrap, all-ones→0 up and 0→all-ones down.
- Direction change takes effect on the next enabled edge; no dead cycle.
- Arithmetic is modulo 2^WIDTH internally; no X propagation from unused bits.
- CountBar is derived from Count only; it is never independently registered or reset.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping: up at Count ≥ limit holds at limit; down at 0 holds at 0.
  - wrap is redefined as a saturation pulse: high the cycle after any enabled step attempted past a bound.
  - The down-count Count > limit clamp and load clamp are unchanged.
- Not defined: wrap-around behaviour as above; no saturation logic synthesised.

Test Plan:
- Reset/hold (WIDTH=4, RESET_VALUE=5): assert reset 2 cycles, then enable=0 for 3 cycles -> Count=5, CountBar=4'hA, wrap=0 throughout.
- Up-wrap (limit=9, up_down=1, enable=1 from Count=0) -> sequence 0..9,0; tc=1 while Count=9; wrap=1 only in the cycle Count first shows 0.
- Down-wrap (limit=9, up_down=0 from Count=2) -> sequence 2,1,0,9,8; wrap=1 in the cycle Count shows 9; tc=1 while Count=0.
- Load priority (load=1, enable=1, load_value=12, limit=9) -> Count=9 next cycle, wrap=0; then load_value=3 -> Count=3.
- Simultaneous events: reset=1 with load=1 and Count=limit=9, enable=1 -> Count=RESET_VALUE, wrap=0; limit=0 with enable=1 -> Count=0, wrap=1 every cycle.
- COUNTER_SATURATE_EN build (limit=9, up from 8) -> Count 8,9,9,9; wrap=1 in the cycle after each held step; down from 1 -> 1,0,0 with wrap=1 after the hold step.
